// File: rtl/dm_sba_pkg.sv
// Shared constants for the debug-module system bus access engine:
// DMI register map, sbcs field positions, sberror codes and FSM states.
package dm_sba_pkg;
    localparam logic [7:0] ADDR_SBCS       = 8'h38;
    localparam logic [7:0] ADDR_SBADDRESS0 = 8'h39;
    localparam logic [7:0] ADDR_SBDATA0    = 8'h3C;

    localparam logic [1:0] DMI_OP_NOP   = 2'd0;
    localparam logic [1:0] DMI_OP_READ  = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE = 2'd2;

    localparam int SBCS_BUSYERROR  = 22;
    localparam int SBCS_BUSY       = 21;
    localparam int SBCS_READONADDR = 20;
    localparam int SBCS_ACCESS_LSB = 17;
    localparam int SBCS_AUTOINC    = 16;
    localparam int SBCS_READONDATA = 15;
    localparam int SBCS_ERROR_LSB  = 12;
    localparam int SBCS_ASIZE_LSB  = 5;

    localparam logic [2:0] SBERR_NONE    = 3'd0;
    localparam logic [2:0] SBERR_TIMEOUT = 3'd1;
    localparam logic [2:0] SBERR_BUS     = 3'd2;
    localparam logic [2:0] SBERR_ALIGN   = 3'd3;
    localparam logic [2:0] SBERR_SIZE    = 3'd4;

    typedef enum logic [1:0] {
        SBA_IDLE,
        SBA_REQ,
        SBA_RESP
    } sba_state_e;
endpackage

// File: rtl/dm_sba_lane.sv
// Byte-lane steering for a 32-bit bus: byte enables, write-data replication
// and zero-extended read extraction, driven by access size and addr[1:0].
module dm_sba_lane (
    input  logic [2:0]  access,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);
    logic [31:0] shifted;

    always_comb begin
        shifted   = rdata >> {addr_lo, 3'b000};
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
        case (access)
            3'd0: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {24'b0, shifted[7:0]};
            end
            3'd1: begin
                be        = 4'b0011 << addr_lo;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {16'b0, shifted[15:0]};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/dm_sba.sv
// System bus access engine: decodes DMI accesses to sbcs/sbaddress0/sbdata0
// and runs single req/gnt/rvalid bus transactions with error tracking.
module dm_sba
    import dm_sba_pkg::*;
#(
    parameter int DMI_ADDR_BITS = 6,
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int TIMEOUT       = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dmi_req_valid_i,
    output logic                     dmi_req_ready_o,
    input  logic [1:0]               dmi_req_op_i,
    input  logic [DMI_ADDR_BITS-1:0] dmi_req_addr_i,
    input  logic [DATA_W-1:0]        dmi_req_data_i,
    output logic                     dmi_resp_valid_o,
    input  logic                     dmi_resp_ready_i,
    output logic [DATA_W-1:0]        dmi_resp_data_o,
    output logic [1:0]               dmi_resp_op_o,
    output logic                     sba_req_o,
    output logic                     sba_we_o,
    output logic [ADDR_W-1:0]        sba_addr_o,
    output logic [DATA_W-1:0]        sba_wdata_o,
    output logic [3:0]               sba_be_o,
    input  logic                     sba_gnt_i,
    input  logic                     sba_rvalid_i,
    input  logic [DATA_W-1:0]        sba_rdata_i,
    input  logic                     sba_err_i
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    sba_state_e        state;
    logic [ADDR_W-1:0] sbaddress;
    logic [31:0]       sbdata, sbcs, rdata_mux;
    logic [2:0]        sbaccess, sberror, access_q;
    logic              sbreadonaddr, sbautoincrement, sbreadondata, sbbusyerror;
    logic [CNT_W-1:0]  cnt;

    logic acc, rd, wr, hit_sbcs, hit_addr, hit_data, busy, can_start;
    logic trig_rd, trig_wr, trig, size_bad, align_bad, collide, timed_out, w1c;
    logic [ADDR_W-1:0] trig_addr;
    logic [31:0]       trig_wdata, lane_wdata, lane_rdata;
    logic [1:0]        trig_lo, align_mask, lane_lo;
    logic [2:0]        lane_access, err_val;
    logic [3:0]        lane_be;
    logic              err_set;

    assign dmi_req_ready_o = !dmi_resp_valid_o;
    assign dmi_resp_op_o   = 2'b00;

    assign acc      = dmi_req_valid_i && dmi_req_ready_o;
    assign rd       = acc && (dmi_req_op_i == DMI_OP_READ);
    assign wr       = acc && (dmi_req_op_i == DMI_OP_WRITE);
    assign hit_sbcs = dmi_req_addr_i == DMI_ADDR_BITS'(ADDR_SBCS);
    assign hit_addr = dmi_req_addr_i == DMI_ADDR_BITS'(ADDR_SBADDRESS0);
    assign hit_data = dmi_req_addr_i == DMI_ADDR_BITS'(ADDR_SBDATA0);
    assign busy     = state != SBA_IDLE;
    assign w1c      = wr && hit_sbcs;

    assign can_start  = !busy && (sberror == SBERR_NONE) && !sbbusyerror;
    assign trig_rd    = can_start && ((wr && hit_addr && sbreadonaddr) ||
                                      (rd && hit_data && sbreadondata));
    assign trig_wr    = can_start && wr && hit_data;
    assign trig       = trig_rd || trig_wr;
    assign collide    = busy && ((wr && (hit_addr || hit_data)) || (rd && hit_data));

    // A trigger from the same DMI write uses the freshly written address/data.
    assign trig_addr  = (wr && hit_addr) ? dmi_req_data_i[ADDR_W-1:0] : sbaddress;
    assign trig_wdata = (wr && hit_data) ? dmi_req_data_i : sbdata;
    assign trig_lo    = 2'(trig_addr);

    always_comb begin
        case (sbaccess)
            3'd0:    align_mask = 2'b00;
            3'd1:    align_mask = 2'b01;
            default: align_mask = 2'b11;
        endcase
    end
    assign size_bad  = sbaccess > 3'd2;
    assign align_bad = (trig_lo & align_mask) != 2'b00;

    assign timed_out = cnt == CNT_W'(TIMEOUT - 1) &&
                       ((state == SBA_REQ && !sba_gnt_i) || (state == SBA_RESP && !sba_rvalid_i));

    // Steering uses trigger-time values when idle, latched size/address in flight.
    assign lane_access = busy ? access_q : sbaccess;
    assign lane_lo     = busy ? 2'(sbaddress) : trig_lo;

    dm_sba_lane u_lane (
        .access    (lane_access),
        .addr_lo   (lane_lo),
        .wdata     (trig_wdata),
        .rdata     (sba_rdata_i),
        .be        (lane_be),
        .wdata_rep (lane_wdata),
        .rdata_ext (lane_rdata)
    );

    always_comb begin
        err_set = 1'b0;
        err_val = SBERR_NONE;
        if (trig && size_bad) begin
            err_set = 1'b1; err_val = SBERR_SIZE;
        end else if (trig && align_bad) begin
            err_set = 1'b1; err_val = SBERR_ALIGN;
        end else if (state == SBA_RESP && sba_rvalid_i && sba_err_i) begin
            err_set = 1'b1; err_val = SBERR_BUS;
        end else if (timed_out) begin
            err_set = 1'b1; err_val = SBERR_TIMEOUT;
        end
    end

    always_comb begin
        sbcs                         = '0;
        sbcs[31:29]                  = 3'd1;
        sbcs[SBCS_BUSYERROR]         = sbbusyerror;
        sbcs[SBCS_BUSY]              = busy;
        sbcs[SBCS_READONADDR]        = sbreadonaddr;
        sbcs[SBCS_ACCESS_LSB +: 3]   = sbaccess;
        sbcs[SBCS_AUTOINC]           = sbautoincrement;
        sbcs[SBCS_READONDATA]        = sbreadondata;
        sbcs[SBCS_ERROR_LSB +: 3]    = sberror;
        sbcs[SBCS_ASIZE_LSB +: 7]    = 7'(ADDR_W);
        sbcs[2:0]                    = 3'b111;
        rdata_mux = '0;
        if (hit_sbcs)      rdata_mux = sbcs;
        else if (hit_addr) rdata_mux = 32'(sbaddress);
        else if (hit_data) rdata_mux = sbdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= SBA_IDLE;
            sbaddress        <= '0;
            sbdata           <= '0;
            sbaccess         <= 3'd2;
            sbreadonaddr     <= 1'b0;
            sbautoincrement  <= 1'b0;
            sbreadondata     <= 1'b0;
            sberror          <= SBERR_NONE;
            sbbusyerror      <= 1'b0;
            access_q         <= '0;
            cnt              <= '0;
            dmi_resp_valid_o <= 1'b0;
            dmi_resp_data_o  <= '0;
            sba_req_o        <= 1'b0;
            sba_we_o         <= 1'b0;
            sba_addr_o       <= '0;
            sba_wdata_o      <= '0;
            sba_be_o         <= '0;
        end else begin
            if (acc) begin
                dmi_resp_valid_o <= 1'b1;
                dmi_resp_data_o  <= rd ? rdata_mux : '0;
            end else if (dmi_resp_ready_i) begin
                dmi_resp_valid_o <= 1'b0;
            end

            if (w1c) begin
                sbreadonaddr    <= dmi_req_data_i[SBCS_READONADDR];
                sbaccess        <= dmi_req_data_i[SBCS_ACCESS_LSB +: 3];
                sbautoincrement <= dmi_req_data_i[SBCS_AUTOINC];
                sbreadondata    <= dmi_req_data_i[SBCS_READONDATA];
            end
            if (wr && hit_addr && !busy) sbaddress <= dmi_req_data_i[ADDR_W-1:0];
            if (wr && hit_data && !busy) sbdata    <= dmi_req_data_i;

            // Error set first, then W1C clears from the same-cycle sbcs write.
            sberror     <= (err_set ? err_val : sberror) &
                           ~(w1c ? dmi_req_data_i[SBCS_ERROR_LSB +: 3] : 3'b000);
            sbbusyerror <= (sbbusyerror || collide) && !(w1c && dmi_req_data_i[SBCS_BUSYERROR]);

            case (state)
                SBA_IDLE: begin
                    if (trig && !size_bad && !align_bad) begin
                        state       <= SBA_REQ;
                        sba_req_o   <= 1'b1;
                        sba_we_o    <= trig_wr;
                        sba_addr_o  <= trig_addr & ~ADDR_W'(3);
                        sba_wdata_o <= lane_wdata;
                        sba_be_o    <= lane_be;
                        access_q    <= sbaccess;
                        cnt         <= '0;
                    end
                end
                SBA_REQ: begin
                    if (sba_gnt_i) begin
                        state     <= SBA_RESP;
                        sba_req_o <= 1'b0;
                        cnt       <= '0;
                    end else if (timed_out) begin
                        state     <= SBA_IDLE;
                        sba_req_o <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SBA_RESP: begin
                    if (sba_rvalid_i) begin
                        state <= SBA_IDLE;
                        if (!sba_err_i) begin
                            if (!sba_we_o)       sbdata    <= lane_rdata;
                            if (sbautoincrement) sbaddress <= sbaddress + ADDR_W'(32'd1 << access_q);
                        end
                    end else if (timed_out) begin
                        state <= SBA_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= SBA_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dm_sba.sv
// Directed bench for dm_sba: DMI register traffic against a simple bus
// responder, checking sbcs/sbaddress0/sbdata0 contents and bus transactions.
module tb_dm_sba;
    localparam logic [5:0] SBCS = 6'h38, SBADDR = 6'h39, SBDATA = 6'h3C;

    logic        clk = 1'b0, rst = 1'b1;
    logic        dmi_req_valid_i = 1'b0, dmi_req_ready_o;
    logic [1:0]  dmi_req_op_i = 2'd0;
    logic [5:0]  dmi_req_addr_i = '0;
    logic [31:0] dmi_req_data_i = '0;
    logic        dmi_resp_valid_o, dmi_resp_ready_i = 1'b1;
    logic [31:0] dmi_resp_data_o;
    logic [1:0]  dmi_resp_op_o;
    logic        sba_req_o, sba_we_o;
    logic [31:0] sba_addr_o, sba_wdata_o;
    logic [3:0]  sba_be_o;
    logic        sba_gnt_i = 1'b0, sba_rvalid_i = 1'b0, sba_err_i = 1'b0;
    logic [31:0] sba_rdata_i = '0;

    int vectors = 0, miscompares = 0;

    // responder controls and transaction log
    logic        gnt_en = 1'b1, bus_err = 1'b0, rvalid_next = 1'b0;
    logic [31:0] bus_rdata = '0;
    int          n_txn = 0, req_cycles = 0;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_be;
    logic        last_we;

    dm_sba dut (
        .clk(clk), .rst(rst),
        .dmi_req_valid_i(dmi_req_valid_i), .dmi_req_ready_o(dmi_req_ready_o),
        .dmi_req_op_i(dmi_req_op_i), .dmi_req_addr_i(dmi_req_addr_i),
        .dmi_req_data_i(dmi_req_data_i), .dmi_resp_valid_o(dmi_resp_valid_o),
        .dmi_resp_ready_i(dmi_resp_ready_i), .dmi_resp_data_o(dmi_resp_data_o),
        .dmi_resp_op_o(dmi_resp_op_o), .sba_req_o(sba_req_o), .sba_we_o(sba_we_o),
        .sba_addr_o(sba_addr_o), .sba_wdata_o(sba_wdata_o), .sba_be_o(sba_be_o),
        .sba_gnt_i(sba_gnt_i), .sba_rvalid_i(sba_rvalid_i), .sba_rdata_i(sba_rdata_i),
        .sba_err_i(sba_err_i)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        sba_gnt_i    = 1'b0;
        sba_rvalid_i = 1'b0;
        sba_err_i    = 1'b0;
        if (sba_req_o) req_cycles++;
        if (rvalid_next) begin
            sba_rvalid_i = 1'b1;
            sba_rdata_i  = bus_rdata;
            sba_err_i    = bus_err;
            rvalid_next  = 1'b0;
        end
        if (sba_req_o && gnt_en) begin
            sba_gnt_i   = 1'b1;
            rvalid_next = 1'b1;
            n_txn++;
            last_addr  = sba_addr_o;
            last_we    = sba_we_o;
            last_be    = sba_be_o;
            last_wdata = sba_wdata_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic dmi(input logic [1:0] op, input logic [5:0] a, input logic [31:0] d,
                       output logic [31:0] r);
        @(negedge clk);
        dmi_req_valid_i = 1'b1;
        dmi_req_op_i    = op;
        dmi_req_addr_i  = a;
        dmi_req_data_i  = d;
        @(posedge clk);
        @(negedge clk);
        dmi_req_valid_i = 1'b0;
        dmi_req_op_i    = 2'd0;
        r = dmi_resp_data_o;
        check("resp_valid", 32'(dmi_resp_valid_o), 32'd1);
        @(posedge clk);
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        logic [31:0] r;
        dmi(2'd2, a, d, r);
    endtask

    task automatic rd(input string tag, input logic [5:0] a, input logic [31:0] exp);
        logic [31:0] r;
        dmi(2'd1, a, 32'h0, r);
        check(tag, r, exp);
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_txn(input string tag, input int n, input logic [31:0] a,
                           input logic we, input logic [3:0] be);
        check({tag, "_n"}, 32'(n_txn), 32'(n));
        check({tag, "_addr"}, last_addr, a);
        check({tag, "_we"}, 32'(last_we), 32'(we));
        check({tag, "_be"}, 32'(last_be), 32'(be));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_req", 32'(sba_req_o), 32'd0);
        check("rst_resp_valid", 32'(dmi_resp_valid_o), 32'd0);
        rd("rst_sbcs", SBCS, 32'h20040407);

        // word writes with autoincrement
        wr(SBCS, 32'h00050000);
        wr(SBADDR, 32'h100);
        wr(SBDATA, 32'hDEADBEEF); settle();
        chk_txn("w1", 1, 32'h100, 1'b1, 4'hF);
        check("w1_wdata", last_wdata, 32'hDEADBEEF);
        wr(SBDATA, 32'hDEADBEEF); settle();
        chk_txn("w2", 2, 32'h104, 1'b1, 4'hF);
        rd("autoinc_addr", SBADDR, 32'h108);
        rd("sbcs_w_ai", SBCS, 32'h20050407);

        // byte read on address write, lane 3
        wr(SBCS, 32'h00100000);
        bus_rdata = 32'hAABBCCDD;
        wr(SBADDR, 32'h203); settle();
        chk_txn("rb", 3, 32'h200, 1'b0, 4'b1000);
        rd("rb_data", SBDATA, 32'h000000AA);

        // misaligned halfword write
        wr(SBCS, 32'h00020000);
        wr(SBADDR, 32'h101);
        wr(SBDATA, 32'h5555); settle();
        check("align_n", 32'(n_txn), 32'd3);
        rd("align_sbcs", SBCS, 32'h20023407);
        wr(SBCS, 32'h00027000);
        rd("align_clr", SBCS, 32'h20020407);

        // halfword write, upper lane
        wr(SBADDR, 32'h102);
        wr(SBDATA, 32'h0000BEEF); settle();
        chk_txn("hw", 4, 32'h100, 1'b1, 4'b1100);
        check("hw_wdata", last_wdata, 32'hBEEFBEEF);

        // unsupported size
        wr(SBCS, 32'h00060000);
        wr(SBDATA, 32'h5555); settle();
        check("size_n", 32'(n_txn), 32'd4);
        rd("size_sbcs", SBCS, 32'h20064407);
        wr(SBCS, 32'h00147000);
        rd("size_clr", SBCS, 32'h20140407);

        // timeout with a busy collision in flight
        gnt_en = 1'b0;
        req_cycles = 0;
        wr(SBADDR, 32'h300);
        rd("busy_sbcs", SBCS, 32'h20340407);
        wr(SBDATA, 32'h1);
        repeat (300) @(negedge clk);
        check("to_req_cycles", 32'(req_cycles), 32'd255);
        check("to_req_low", 32'(sba_req_o), 32'd0);
        check("to_n", 32'(n_txn), 32'd4);
        rd("to_sbcs", SBCS, 32'h20541407);
        rd("collide_dropped", SBDATA, 32'h5555);
        gnt_en = 1'b1;
        wr(SBADDR, 32'h400); settle();
        check("blocked1_n", 32'(n_txn), 32'd4);
        wr(SBCS, 32'h00141000);
        rd("clr_err_only", SBCS, 32'h20540407);
        wr(SBADDR, 32'h400); settle();
        check("blocked2_n", 32'(n_txn), 32'd4);
        wr(SBCS, 32'h00540000);
        rd("clr_busyerr", SBCS, 32'h20140407);
        bus_rdata = 32'h12345678;
        wr(SBADDR, 32'h404); settle();
        chk_txn("unblocked", 5, 32'h404, 1'b0, 4'hF);
        rd("unblocked_data", SBDATA, 32'h12345678);

        // bus error
        bus_err = 1'b1;
        bus_rdata = 32'h0BADBAD0;
        wr(SBADDR, 32'h500); settle();
        bus_err = 1'b0;
        check("berr_n", 32'(n_txn), 32'd6);
        rd("berr_sbcs", SBCS, 32'h20142407);
        rd("berr_data", SBDATA, 32'h12345678);

        // read on data
        wr(SBCS, 32'h0004F000);
        rd("rod_sbcs", SBCS, 32'h20048407);
        bus_rdata = 32'hCAFEF00D;
        rd("rod_old", SBDATA, 32'h12345678); settle();
        chk_txn("rod", 7, 32'h500, 1'b0, 4'hF);
        rd("rod_new", SBDATA, 32'hCAFEF00D); settle();

        // address wrap
        wr(SBCS, 32'h00050000);
        wr(SBADDR, 32'hFFFFFFFC);
        wr(SBDATA, 32'h77); settle();
        chk_txn("wrap", 9, 32'hFFFFFFFC, 1'b1, 4'hF);
        rd("wrap_addr", SBADDR, 32'h0);

        // reset while requesting
        gnt_en = 1'b0;
        wr(SBDATA, 32'h99);
        @(negedge clk);
        check("pre_rst_req", 32'(sba_req_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_req", 32'(sba_req_o), 32'd0);
        gnt_en = 1'b1;
        rd("post_rst_sbcs", SBCS, 32'h20040407);
        rd("post_rst_addr", SBADDR, 32'h0);
        settle();
        check("post_rst_n", 32'(n_txn), 32'd9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dm_sba.md
Name: dm_sba

Overview:
Parametrised System Bus Access (SBA) engine for the debug module, per RISC-V Debug Spec 0.13. Lets the debugger read and write memory while the core keeps running, instead of going through halt-based register and memory paths. Decodes DMI accesses to sbcs (0x38), sbaddress0 (0x39) and sbdata0 (0x3C), then drives a req/gnt/rvalid memory bus master port. Supports auto-increment, read-on-address, read-on-data, byte/half/word sizes, bus errors and timeout.

Parameters:
DMI_ADDR_BITS, 6, DMI address width
ADDR_W, 32, system bus address width (1..32), reported in sbasize
DATA_W, 32, bus data width; fixed 32 in this generation
TIMEOUT, 255, cycles awaiting gnt or rvalid before sberror=1

Ports:
clk  in  1  single clock
rst  in  1  synchronous reset, active-high
dmi_req_valid_i  in  1  DMI request valid
dmi_req_ready_o  out  1  DMI request accepted when valid&ready
dmi_req_op_i  in  2  1=read, 2=write, others=nop
dmi_req_addr_i  in  DMI_ADDR_BITS  register address
dmi_req_data_i  in  32  write data
dmi_resp_valid_o  out  1  response valid
dmi_resp_ready_i  in  1  response consumed
dmi_resp_data_o  out  32  read data, 0 for writes and nops
dmi_resp_op_o  out  2  always 0 (success); SBA errors appear only in sbcs
sba_req_o  out  1  bus request, held until sba_gnt_i
sba_we_o  out  1  1=write
sba_addr_o  out  ADDR_W  byte address
sba_wdata_o  out  32  write data, lane-replicated
sba_be_o  out  4  byte enables
sba_gnt_i  in  1  request granted
sba_rvalid_i  in  1  response phase, 1 cycle
sba_rdata_i  in  32  read data
sba_err_i  in  1  bus error, qualified by sba_rvalid_i

Behaviour:
- Reset (sync, rst=1 at clk edge): all outputs 0. sbaddress=0, sbdata=0, sbaccess=2, flags 0, sberror=0, FSM=IDLE. rst mid-transaction drops sba_req_o next cycle, no retry.
- DMI: dmi_req_ready_o = !dmi_resp_valid_o. Response is registered, valid 1 cycle after acceptance, held until dmi_resp_ready_i.
- Reads of unmapped addresses return 0. Writes to unmapped addresses are ignored.
- sbcs read: [31:29]=1, [22]=sbbusyerror, [21]=sbbusy (FSM!=IDLE), [20]=sbreadonaddr, [19:17]=sbaccess, [16]=sbautoincrement, [15]=sbreadondata, [14:12]=sberror, [11:5]=ADDR_W, [2:0]=3'b111.
- sbcs write: sbbusyerror and sberror are W1C (clear bits where data is 1). Other RW fields are written directly.
- FSM states:
  - IDLE -> REQ on a trigger.
  - REQ: assert sba_req_o. On sba_gnt_i go to RESP.
  - RESP: on sba_rvalid_i go to IDLE.
  - Timeout: a counter reset on entry to REQ and on entry to RESP reaches TIMEOUT -> sberror=1, go to IDLE, no increment.
- Triggers (only when IDLE, sberror==0 and sbbusyerror==0; otherwise no bus access):
  - Write sbaddress0 with sbreadonaddr=1 -> read.
  - Write sbdata0 -> write.
  - Read sbdata0 with sbreadondata=1 -> returns current sbdata, then starts a read.
- Busy collision: any write to sbaddress0/sbdata0, or read of sbdata0, while sbbusy -> sbbusyerror=1. Writes are dropped; reads return stale sbdata.
- Size check at trigger: sbaccess>2 -> sberror=4. Address not aligned to 2^sbaccess -> sberror=3. No bus access in either case.
- Lane handling:
  - Writes: wdata replicates the low 8/16 bits. be = 0001<<a[1:0] (byte), 0011<<a[1:0] (half), 1111 (word).
  - Reads: extract the lane selected by a[1:0], zero-extend into sbdata.
- Completion:
  - sba_err_i=1 -> sberror=2, sbdata unchanged, no increment.
  - Otherwise, if sbautoincrement: sbaddress += 2^sbaccess, modulo 2^ADDR_W (wraps).
- sba_addr_o is sbaddress[ADDR_W-1:2], 2'b0 concatenated. sbaddress0 writes wider than ADDR_W are truncated.
- Simultaneous events: if completion and a DMI access hit the same cycle, the access sees busy (FSM state is registered). Completion updates win over DMI writes to the same field except the W1C clears, which apply afterwards.

Decomposition:
- Shared package/defines: DMI register addresses (SBCS=0x38, SBADDRESS0=0x39, SBDATA0=0x3C); sbcs bit positions; sberror codes (0 none, 1 timeout, 2 bus, 3 align, 4 size); DMI op codes.
- One sub-module, dm_sba_lane: combinational byte-enable generation, write replication and read extraction from (sbaccess, addr[1:0]).

Test Plan:
- Write sbcs=0x00050000 (word, autoinc), sbaddress0=0x100, then sbdata0=0xDEADBEEF twice -> bus writes to 0x100 and 0x104 with be=1111; sbaddress0 reads 0x108.
- sbaccess=0 with sbreadonaddr, write sbaddress0=0x203, bus returns 0xAABBCCDD -> sba_addr=0x200, be=1000; sbdata0 reads 0x000000AA.
- sbaccess=1, sbaddress0=0x101, write sbdata0 -> no sba_req_o; sbcs[14:12]=3. Write sbcs with bit12..14 set -> sberror=0.
- Hold sba_gnt_i=0 for 300 cycles during a read -> sba_req_o drops at cycle 255; sberror=1, sbbusy=0.
- During an in-flight read, write sbdata0=0x1 -> sbbusyerror=1 and no second bus write. Next trigger is blocked until the W1C of bit 22.
- sbaddress0=0xFFFFFFFC with word autoinc and one write -> sbaddress0 wraps to 0x0. Assert rst during the REQ state -> sba_req_o=0 next cycle and sbcs reads its reset value 0x20040407 (ADDR_W=32).
